// File: rtl/adc_pulse_trigger.sv
// Per-channel trigger front end. It detects rising threshold crossings, timestamps them,
// searches a window for the peak and hands one event downstream over valid/ready.
module adc_pulse_trigger #(
  parameter int DATA_W = 14,
  parameter int TS_W   = 48,
  parameter int WIN_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              adc_valid,
  input  logic [DATA_W-1:0] thresh,
  input  logic [WIN_W-1:0]  peak_win,
  input  logic [WIN_W-1:0]  holdoff,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [TS_W-1:0]   evt_ts,
  output logic [DATA_W-1:0] evt_peak,
  output logic [15:0]       drop_cnt,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, SEARCH, HOLDOFF} state_t;

  state_t            state, state_nxt, close_state;
  logic [TS_W-1:0]   ts_cnt, cand_ts, cand_ts_nxt, close_ts;
  logic [DATA_W-1:0] prev, cand_peak, cand_peak_nxt, close_peak, peak_max;
  logic [WIN_W-1:0]  win_cnt, win_cnt_nxt, ho_cnt, ho_cnt_nxt;
  logic              crossing, close, slot_free;

  assign crossing    = adc_valid && (adc_data >= thresh) && (prev < thresh);
  assign peak_max    = (adc_data > cand_peak) ? adc_data : cand_peak;
  assign close_state = (holdoff == '0) ? IDLE : HOLDOFF;
  assign slot_free   = !evt_valid || evt_ready;
  assign busy        = (state != IDLE);

  // The timestamp and the previous-sample history keep running in every state and
  // regardless of enable. prev resets to all-ones so the first sample cannot trigger.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_cnt <= '0;
      prev   <= '1;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      ts_cnt <= ts_cnt + TS_W'(1);
      if (adc_valid) prev <= adc_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cand_ts   <= '0;
      cand_peak <= '0;
      win_cnt   <= '0;
      ho_cnt    <= '0;
    end else begin
      state     <= state_nxt;
      cand_ts   <= cand_ts_nxt;
      cand_peak <= cand_peak_nxt;
      win_cnt   <= win_cnt_nxt;
      ho_cnt    <= ho_cnt_nxt;
    end
  end

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    state_nxt     = state;
    cand_ts_nxt   = cand_ts;
    cand_peak_nxt = cand_peak;
    win_cnt_nxt   = win_cnt;
    ho_cnt_nxt    = ho_cnt;
    close         = 1'b0;
    close_ts      = cand_ts;
    close_peak    = cand_peak;

    if (!enable) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (crossing) begin
            cand_ts_nxt   = ts_cnt;
            cand_peak_nxt = adc_data;
            win_cnt_nxt   = peak_win;
            if (peak_win == '0) begin
              // A zero-length window closes the event on the crossing sample itself.
              close      = 1'b1;
              close_ts   = ts_cnt;
              close_peak = adc_data;
              ho_cnt_nxt = holdoff;
              state_nxt  = close_state;
            end else begin
              state_nxt = SEARCH;
            end
          end
        end
        SEARCH: begin
          if (adc_valid) begin
            cand_peak_nxt = peak_max;
            win_cnt_nxt   = win_cnt - WIN_W'(1);
            if (win_cnt == WIN_W'(1)) begin
              close      = 1'b1;
              close_peak = peak_max;
              ho_cnt_nxt = holdoff;
              state_nxt  = close_state;
            end
          end
        end
        HOLDOFF: begin
          if (adc_valid) begin
            ho_cnt_nxt = ho_cnt - WIN_W'(1);
            if (ho_cnt == WIN_W'(1)) state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // One-deep output slot; a close that finds it occupied is counted and discarded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_valid <= 1'b0;
      evt_ts    <= '0;
      evt_peak  <= '0;
      drop_cnt  <= '0;
    end else begin
      if (close && slot_free) begin
        evt_valid <= 1'b1;
        evt_ts    <= close_ts;
        evt_peak  <= close_peak;
      end else if (evt_valid && evt_ready) begin
        evt_valid <= 1'b0;
      end
      if (close && !slot_free && (drop_cnt != 16'hFFFF)) drop_cnt <= drop_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_adc_pulse_trigger.sv
// Scoreboard bench for adc_pulse_trigger. Expected events are queued as stimulus is driven
// and compared as the DUT hands them off; a narrow-timestamp instance covers wrap-around.
module tb_adc_pulse_trigger;

  typedef struct {
    logic [47:0] ts;
    logic [13:0] peak;
  } evt_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b1;
  logic [13:0] adc_data = '0;
  logic        adc_valid = 1'b0;
  logic [13:0] thresh = 14'd100;
  logic [7:0]  peak_win = 8'd3;
  logic [7:0]  holdoff = 8'd2;
  logic        evt_ready = 1'b1;

  logic        evt_valid, busy;
  logic [47:0] evt_ts;
  logic [13:0] evt_peak;
  logic [15:0] drop_cnt;

  logic        evt_valid_s, busy_s;
  logic [5:0]  evt_ts_s;
  logic [13:0] evt_peak_s;
  logic [15:0] drop_cnt_s;

  logic [47:0] tb_ts;
  evt_t        exp_q[$];
  evt_t        mon_e;
  int          n_checks = 0;
  int          n_pass = 0;
  int          exp_drop = 0;

  adc_pulse_trigger dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .adc_data(adc_data), .adc_valid(adc_valid),
    .thresh(thresh), .peak_win(peak_win), .holdoff(holdoff), .evt_valid(evt_valid),
    .evt_ready(evt_ready), .evt_ts(evt_ts), .evt_peak(evt_peak), .drop_cnt(drop_cnt), .busy(busy)
  );

  adc_pulse_trigger #(.TS_W(6)) dut_s (
    .clk(clk), .rst_n(rst_n), .enable(enable), .adc_data(adc_data), .adc_valid(adc_valid),
    .thresh(thresh), .peak_win(peak_win), .holdoff(holdoff), .evt_valid(evt_valid_s),
    .evt_ready(evt_ready), .evt_ts(evt_ts_s), .evt_peak(evt_peak_s), .drop_cnt(drop_cnt_s),
    .busy(busy_s)
  );

  always #5 clk = ~clk;

  // Cycle counter: at 1 time unit after each edge it equals the timestamp the DUT captures next edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tb_ts <= '0;
    else        tb_ts <= tb_ts + 48'd1;
  end

  always @(negedge clk) begin
    if (rst_n && evt_valid && evt_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_event: got ts=%0d peak=%0d, required no event", evt_ts, evt_peak);
      end else begin
        mon_e = exp_q.pop_front();
        if (evt_ts !== mon_e.ts || evt_peak !== mon_e.peak)
          $display("FAIL event_payload: got ts=%0d peak=%0d, required ts=%0d peak=%0d",
                   evt_ts, evt_peak, mon_e.ts, mon_e.peak);
        else n_pass++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [13:0] d);
    step();
    adc_valid = 1'b1;
    adc_data  = d;
  endtask

  task automatic gap();
    step();
    adc_valid = 1'b0;
  endtask

  task automatic push(input logic [47:0] ts, input logic [13:0] peak);
    evt_t e;
    e.ts   = ts;
    e.peak = peak;
    exp_q.push_back(e);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({evt_valid, busy, evt_ts, evt_peak, drop_cnt} !== '0)
      $display("FAIL reset_outputs: got valid=%0b busy=%0b ts=%0d peak=%0d drop=%0d, required all 0",
               evt_valid, busy, evt_ts, evt_peak, drop_cnt);
    else n_pass++;
    rst_n = 1'b1;
    send(14'd4000);
    gap();
    n_checks++;
    if (busy !== 1'b0) $display("FAIL reset_first_sample: got busy=%0b, required 0", busy);
    else n_pass++;
  endtask

  task automatic test_basic();
    logic [47:0] t;
    peak_win = 8'd3; holdoff = 8'd2; evt_ready = 1'b1;
    send(14'd50);
    send(14'd120); t = tb_ts; push(t, 14'd180);
    send(14'd180);
    n_checks++;
    if (busy !== 1'b1) $display("FAIL basic_busy_rise: got %0b, required 1", busy); else n_pass++;
    send(14'd150);
    send(14'd90);
    n_checks++;
    if (evt_valid !== 1'b0) $display("FAIL basic_early_valid: got %0b, required 0", evt_valid); else n_pass++;
    send(14'd200);
    n_checks++;
    if (evt_valid !== 1'b1) $display("FAIL basic_valid_time: got %0b, required 1", evt_valid); else n_pass++;
    send(14'd60);
    n_checks++;
    if (busy !== 1'b1) $display("FAIL basic_busy_holdoff: got %0b, required 1", busy); else n_pass++;
    gap();
    n_checks++;
    if (busy !== 1'b0) $display("FAIL basic_busy_fall: got %0b, required 0", busy); else n_pass++;
    wait_drain();
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL basic_missing: got %0d pending, required 0", exp_q.size());
    else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [47:0] t1;
    evt_ready = 1'b0;
    send(14'd50);
    send(14'd120); t1 = tb_ts; push(t1, 14'd180);
    send(14'd180); send(14'd150); send(14'd90); send(14'd200); send(14'd60);
    send(14'd50); send(14'd130); send(14'd140); send(14'd110); send(14'd70);
    send(14'd60);
    exp_drop++;
    n_checks++;
    if (drop_cnt !== 16'(exp_drop)) $display("FAIL bp_drop: got %0d, required %0d", drop_cnt, exp_drop);
    else n_pass++;
    n_checks++;
    if (evt_valid !== 1'b1 || evt_ts !== t1 || evt_peak !== 14'd180)
      $display("FAIL bp_hold: got valid=%0b ts=%0d peak=%0d, required 1 ts=%0d peak=180",
               evt_valid, evt_ts, evt_peak, t1);
    else n_pass++;
    send(14'd60);
    gap();
    evt_ready = 1'b1;
    wait_drain();
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL bp_missing: got %0d pending, required 0", exp_q.size());
    else n_pass++;
    step();
    n_checks++;
    if (evt_valid !== 1'b0) $display("FAIL bp_second_seen: got valid=%0b, required 0", evt_valid);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [47:0] t_b;
    evt_ready = 1'b0;
    send(14'd50);
    send(14'd120); push(tb_ts, 14'd180);
    send(14'd180); send(14'd150); send(14'd90); send(14'd60); send(14'd60);
    send(14'd50);
    send(14'd130); t_b = tb_ts; push(t_b, 14'd140);
    send(14'd140); send(14'd110); send(14'd70);
    evt_ready = 1'b1;
    gap();
    n_checks++;
    if (evt_valid !== 1'b1 || evt_ts !== t_b || evt_peak !== 14'd140 || drop_cnt !== 16'(exp_drop))
      $display("FAIL b2b_reload: got valid=%0b ts=%0d peak=%0d drop=%0d, required 1 ts=%0d peak=140 drop=%0d",
               evt_valid, evt_ts, evt_peak, drop_cnt, t_b, exp_drop);
    else n_pass++;
    send(14'd60); send(14'd60);
    gap();
    wait_drain();
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL b2b_missing: got %0d pending, required 0", exp_q.size());
    else n_pass++;
  endtask

  task automatic test_zero_window();
    logic [47:0] t;
    peak_win = 8'd0; holdoff = 8'd0; evt_ready = 1'b1;
    send(14'd99);
    send(14'd100); t = tb_ts; push(t, 14'd100);
    send(14'd99);
    n_checks++;
    if (evt_valid !== 1'b1 || evt_ts !== t || busy !== 1'b0)
      $display("FAIL zw_first: got valid=%0b ts=%0d busy=%0b, required 1 ts=%0d busy=0",
               evt_valid, evt_ts, busy, t);
    else n_pass++;
    send(14'd100); t = tb_ts; push(t, 14'd100);
    gap();
    n_checks++;
    if (evt_valid !== 1'b1 || evt_ts !== t || evt_peak !== 14'd100 || busy !== 1'b0)
      $display("FAIL zw_second: got valid=%0b ts=%0d peak=%0d busy=%0b, required 1 ts=%0d peak=100 busy=0",
               evt_valid, evt_ts, evt_peak, busy, t);
    else n_pass++;
    wait_drain();
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL zw_missing: got %0d pending, required 0", exp_q.size());
    else n_pass++;
  endtask

  task automatic test_enable_abort();
    peak_win = 8'd3; holdoff = 8'd2; evt_ready = 1'b1;
    send(14'd50); send(14'd120); send(14'd180);
    n_checks++;
    if (busy !== 1'b1) $display("FAIL en_busy_rise: got %0b, required 1", busy); else n_pass++;
    enable = 1'b0;
    send(14'd150);
    n_checks++;
    if (busy !== 1'b0) $display("FAIL en_busy_fall: got %0b, required 0", busy); else n_pass++;
    send(14'd90); send(14'd60);
    gap();
    repeat (3) step();
    n_checks++;
    if (evt_valid !== 1'b0 || drop_cnt !== 16'(exp_drop))
      $display("FAIL en_no_event: got valid=%0b drop=%0d, required 0 drop=%0d", evt_valid, drop_cnt, exp_drop);
    else n_pass++;
    enable = 1'b1;
  endtask

  task automatic test_reset_holdoff();
    evt_ready = 1'b0;
    send(14'd50);
    send(14'd120); push(tb_ts, 14'd180);
    send(14'd180); send(14'd150); send(14'd90); send(14'd200);
    gap();
    n_checks++;
    if (busy !== 1'b1 || evt_valid !== 1'b1)
      $display("FAIL rh_pre: got busy=%0b valid=%0b, required 1 1", busy, evt_valid);
    else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    exp_q.delete();
    exp_drop = 0;
    n_checks++;
    if ({evt_valid, busy, evt_ts, evt_peak, drop_cnt} !== '0)
      $display("FAIL rh_outputs: got valid=%0b busy=%0b ts=%0d peak=%0d drop=%0d, required all 0",
               evt_valid, busy, evt_ts, evt_peak, drop_cnt);
    else n_pass++;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    evt_ready = 1'b1;
    send(14'd4000);
    gap();
    n_checks++;
    if (busy !== 1'b0) $display("FAIL rh_first_sample: got busy=%0b, required 0", busy); else n_pass++;
    step();
    n_checks++;
    if (evt_valid !== 1'b0) $display("FAIL rh_no_event: got valid=%0b, required 0", evt_valid); else n_pass++;
  endtask

  task automatic test_ts_wrap();
    logic [47:0] t;
    peak_win = 8'd0; holdoff = 8'd0; evt_ready = 1'b1;
    for (int i = 0; i < 70 && tb_ts[5:0] != 6'd62; i++) step();
    send(14'd50);
    send(14'd120); t = tb_ts; push(t, 14'd120);
    gap();
    n_checks++;
    if (evt_valid_s !== 1'b1 || evt_ts_s !== t[5:0] || evt_ts_s !== 6'd0)
      $display("FAIL wrap_ts: got valid=%0b ts=%0d, required 1 ts=0", evt_valid_s, evt_ts_s);
    else n_pass++;
    wait_drain();
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL wrap_missing: got %0d pending, required 0", exp_q.size());
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_zero_window();
    test_enable_abort();
    test_reset_holdoff();
    test_ts_wrap();
    repeat (2) step();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within 200000 time units");
    $fatal(1);
  end

endmodule

// File: doc/adc_pulse_trigger.md
# adc_pulse_trigger

Per-channel front-end trigger stage that sits directly upstream of the channel event-packing module. It watches the raw ADC sample stream for a rising threshold crossing and timestamps the crossing. It then searches a programmable window for the pulse peak and hands one event (timestamp, peak) downstream over a valid/ready handshake. A hold-off period and a saturating drop counter cover pile-up and back-pressure.

## Interface
- DATA_W, 14: ADC sample width (unsigned)
- TS_W, 48: timestamp counter width
- WIN_W, 8: width of the peak-window and hold-off length fields
- clk, in, 1: single system clock; all logic on its rising edge
- rst_n, in, 1: reset, asynchronous and active-low
- enable, in, 1: trigger enable; low aborts any search in progress
- adc_data, in, DATA_W: ADC sample, unsigned
- adc_valid, in, 1: adc_data valid this cycle
- thresh, in, DATA_W: trigger threshold, compared live
- peak_win, in, WIN_W: number of valid samples after the crossing sample that are included in the peak search
- holdoff, in, WIN_W: number of valid samples ignored after an event closes
- evt_valid, out, 1: event available
- evt_ready, in, 1: downstream accepts the event
- evt_ts, out, TS_W: timestamp of the crossing sample
- evt_peak, out, DATA_W: maximum sample in the window, crossing sample included
- drop_cnt, out, 16: events lost to a full output slot; saturates at 0xFFFF
- busy, out, 1: FSM not in IDLE

## Operation
- ts_cnt: free-running, +1 every clk, wraps modulo 2^TS_W, independent of enable.
- prev: last valid sample; updated on every adc_valid in all states.
- Crossing: adc_valid && adc_data >= thresh && prev < thresh.
- FSM states: IDLE, SEARCH, HOLDOFF.
  - IDLE to SEARCH: on a crossing with enable=1. Latch ts_cnt as cand_ts, adc_data as cand_peak, and peak_win as win_cnt.
    - If peak_win=0, the event closes immediately on the crossing cycle; the FSM goes to HOLDOFF, or to IDLE if holdoff=0.
  - SEARCH: on each valid sample, cand_peak = max(cand_peak, adc_data) and win_cnt decrements. When the sample that brings win_cnt to 0 is consumed, the event closes and that sample is included in the peak.
  - Close: the FSM latches holdoff into ho_cnt and goes to HOLDOFF, or to IDLE if holdoff=0.
  - HOLDOFF: each valid sample decrements ho_cnt. When the sample that brings ho_cnt to 0 is consumed, the FSM goes to IDLE. That sample cannot trigger.
  - Crossings in SEARCH or HOLDOFF are ignored and not counted.
- Event emission on close:
  - Slot free (evt_valid=0, or evt_valid && evt_ready this same cycle): load evt_ts/evt_peak and set evt_valid.
  - Slot occupied: discard the event, drop_cnt += 1 (saturating). The FSM proceeds exactly as in the free case.
- Output slot: evt_valid clears on evt_valid && evt_ready unless it is reloaded in the same cycle. evt_ts/evt_peak hold stable while evt_valid && !evt_ready.
- enable=0: the FSM goes to IDLE on the next edge. A search in progress is abandoned with no event and no drop count. An already-loaded output event is unaffected. ts_cnt and prev keep running.
- Width rules: unsigned compares only; ts is captured without arithmetic; the max is a plain unsigned compare.

## Timing
- Reset values: evt_valid=0, evt_ts=0, evt_peak=0, drop_cnt=0, busy=0, state=IDLE, ts_cnt=0, prev=all-ones. Because prev resets to all-ones, the first sample after reset can never trigger.
- Reset is asynchronous. Asserting it mid-search or mid-hold-off clears everything; no partial event is emitted.
- Crossing sample presented in cycle C (ts_cnt=T): evt_ts=T.
  - peak_win=0: evt_valid high from C+1.
  - peak_win=P: evt_valid high one cycle after the P-th subsequent valid sample.
- busy: rises at C+1 and falls one cycle after the final hold-off sample. For peak_win=0 and holdoff=0, busy never rises.
- Gaps in adc_valid stall the window and hold-off counters only; ts_cnt keeps counting.
- Throughput: one event per (1 + peak_win + holdoff) valid samples, minimum.

## Test plan
- thresh=100, peak_win=3, holdoff=2; samples 50,120,180,150,90,200,... from ts 10 -> one event {ts=11, peak=180} at cycle 15. The sample 200 arrives during HOLDOFF and causes no trigger.
- Same stimulus with evt_ready=0 held, and a second pulse after hold-off -> first event held stable, drop_cnt=1. After evt_ready=1, only the first event is seen.
- Close on the same cycle as evt_ready=1 with the slot full -> new event loaded, evt_valid stays high, drop_cnt unchanged.
- peak_win=0, holdoff=0; samples 99,100,99,100 with thresh=100 -> two events, each with peak=100 and one cycle after its crossing; busy stays 0.
- enable dropped mid-SEARCH -> no event, drop_cnt=0, busy low the next cycle. rst_n pulsed mid-HOLDOFF -> all outputs 0, and the first post-reset sample of 4000 does not trigger.
- Force ts_cnt near 2^TS_W-1 -> evt_ts wraps correctly to a small value.
